cal_multi_gen: RTL and testbench
================================

Name: cal_multi_gen

Overview:
Multi-channel calibration pulse generator for the NMR front end. It is the parametrised successor of the single-output CAL block and runs entirely in the clk_sys domain. Each channel produces a square-wave calibration pulse train with its own half-period, loaded through a shadow-register interface. Bursts have a programmable length, and a continuous mode runs until a graceful stop.

Parameters:
CH_NUM, 4, number of calibration output channels (1..16)
PARA_W, 6, width of the half-period parameter
BURST_W, 8, width of the burst-length field
CH_W, $clog2(CH_NUM) (min 1), width of the channel select

Ports:
clk_sys  in  1  system clock; the only clock
rst  in  1  synchronous, active-high reset
cal_load  in  1  1-cycle strobe: write cal_para into the shadow register of channel cal_ch
cal_ch  in  CH_W  channel select for cal_load
cal_para  in  PARA_W  half-period code; half-period H = cal_para+1 clk_sys cycles
cal_mode  in  1  0 = burst, 1 = continuous; sampled with cal_start
burst_len  in  BURST_W  periods per channel in burst mode; sampled with cal_start
cal_start  in  1  1-cycle strobe: start a run
cal_stop  in  1  1-cycle strobe: graceful stop
cal  out  CH_NUM  calibration outputs
busy  out  1  high while a run is active
done  out  1  1-cycle pulse at end of run

Behaviour:
- Reset (synchronous, at the clk_sys edge with rst=1):
  - cal=0, busy=0, done=0, FSM=IDLE.
  - All shadow and active half-period registers = all-ones (H=2^PARA_W).
  - Period counters = 0. Latched burst_len and mode = 0.
  - Reset mid-run aborts immediately; done is not pulsed.
- Load:
  - cal_load writes the shadow of channel cal_ch at the same edge, in any state.
  - cal_ch >= CH_NUM: the write is ignored.
  - A load while busy does not affect the running waveform.
- FSM states:
  - IDLE:
    - cal_start=1 and cal_stop=0 at edge k -> RUN.
    - At edge k: active <= shadow for all channels; mode and burst_len latched; counters cleared.
    - Edge k+1: busy=1 and cal=all ones.
    - cal_start together with cal_stop: stop wins; stay IDLE, no done.
    - Burst mode with burst_len=0: go to DONE; no cal edges; busy stays 0.
  - RUN:
    - Each channel is high for H cycles, then low for H cycles. That is one period.
    - The channel re-rises immediately unless it has finished.
    - Burst mode: a channel finishes after burst_len complete periods and then holds 0.
    - When all channels have finished -> DONE.
    - cal_start is ignored.
    - cal_stop -> STOP.
  - STOP:
    - Each channel completes its current period (including the low half), then holds 0.
    - A channel already low-finished stays 0.
    - When all channels are idle -> DONE.
    - cal_stop and cal_start are ignored.
  - DONE: for one cycle, done=1 and busy=0; then -> IDLE.
- Timing and counting:
  - busy=1 from the cycle after start acceptance until the cycle done is asserted (exclusive).
  - Half-period counter width is PARA_W+1; it compares against the active code and wraps to 0 on each toggle.
  - Period counter width is BURST_W; it is never compared past burst_len, so there is no overflow.
- Channel phase and tie-breaks:
  - All channels rise in phase on the first RUN cycle; there is no re-alignment afterwards.
  - cal_stop in the same cycle a burst completes: burst completion takes precedence.
  - The done pulse is issued once.

Decomposition:
- Package cal_pkg:
  - FSM state enum (IDLE, RUN, STOP, DONE).
  - Localparam for reset half-period code (all ones).
  - Function for CH_W min-1 clog2.
- Sub-module cal_ch_gen, one per channel via generate:
  - Holds the active half-period register, half counter, period counter, output flop.
  - Inputs: start, stop_req, mode, burst_len.
  - Outputs: cal bit, finished.
- The top holds the shadow registers, FSM, busy/done and the all-finished reduction.

Test Plan:
1. Reset check:
   - Stimulus: assert rst for 3 cycles.
   - Required: cal=0, busy=0, done=0; with no loads, start burst_len=1 gives each channel 64 cycles high, 64 low, then done.
2. Two-channel burst:
   - Stimulus: load ch0 para=2 (H=3), ch1 para=0 (H=1); burst_len=2; mode=0; start.
   - ch0: 1,1,1,0,0,0 twice (12 cycles).
   - ch1: 1,0,1,0, then low.
   - done 1 cycle after ch0's final low cycle; busy high exactly 12 cycles.
3. Continuous mode with stop:
   - Stimulus: ch0 para=3 (H=4); mode=1; start; cal_stop on the 2nd high cycle of period 3.
   - Required: ch0 finishes period 3 (2 more high, 4 low), then holds 0; done follows.
4. Load during run:
   - Stimulus: load ch0 para=5 mid-burst.
   - Required: running waveform unchanged; the next start uses H=6.
   - Also: load with cal_ch=CH_NUM is ignored.
5. Edge cases:
   - burst_len=0 start -> done next cycle, cal never toggles, busy stays 0.
   - start+stop in the same cycle -> no run, no done.
   - cal_start during RUN is ignored.
6. Reset mid-run:
   - Stimulus: rst during RUN.
   - Required: cal=0 and busy=0 the next cycle, no done; a subsequent start works from reset defaults.

Source files
------------

// File: rtl/cal_pkg.sv
// Shared types and helpers for the multi-channel calibration pulse generator.
package cal_pkg;

  // Run-control states of the generator.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP,
    DONE
  } cal_state_e;

  // Half-period codes reset to this bit replicated over the code width,
  // i.e. the longest half-period (2^PARA_W cycles).
  localparam logic RST_CODE_BIT = 1'b1;

  // Channel-select width: clog2 of the channel count, never below one bit.
  function automatic int ch_w_calc(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cal_ch_gen.sv
// One calibration channel: square wave of H high / H low cycles per period,
// with burst counting and graceful stop at the end of the current period.
module cal_ch_gen
  import cal_pkg::*;
#(
  parameter int PARA_W  = 6,
  parameter int BURST_W = 8
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               start,
  input  logic               launch,
  input  logic               run,
  input  logic               stop_req,
  input  logic               mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [PARA_W-1:0]  para,
  output logic               cal,
  output logic               finished
);

  logic [PARA_W-1:0]  active;
  logic [PARA_W:0]    half_cnt;
  logic [BURST_W-1:0] per_cnt;
  logic               fin;
  logic               half_end;
  logic               period_end;
  logic               last_period;

  // End-of-half / end-of-period decode; finished looks ahead so the FSM
  // leaves RUN/STOP on the same edge the last low half ends.
  // NOTE: every signal written here is assigned on every pass, so no latch is inferred.
  always_comb begin
    half_end    = (half_cnt == {1'b0, active});
    period_end  = run && !fin && half_end && !cal;
    last_period = stop_req || (!mode && ((per_cnt + BURST_W'(1)) == burst_len));
    finished    = fin || (period_end && last_period);
  end

  // Waveform state: counters, output flop and the finished flag.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      active   <= {PARA_W{RST_CODE_BIT}};
      half_cnt <= '0;
      per_cnt  <= '0;
      cal      <= 1'b0;
      fin      <= 1'b0;
    end else if (start) begin
      active   <= para;
      half_cnt <= '0;
      per_cnt  <= '0;
      cal      <= launch;
      fin      <= 1'b0;
    end else if (run && !fin) begin
      if (!half_end) begin
        half_cnt <= half_cnt + 1'b1;
      end else begin
        half_cnt <= '0;
        if (cal) begin
          cal <= 1'b0;
        end else if (last_period) begin
          fin <= 1'b1;
        end else begin
          cal <= 1'b1;
          if (!mode) per_cnt <= per_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cal_multi_gen.sv
// Multi-channel calibration pulse generator: shadow half-period registers,
// run-control FSM with registered busy/done, one cal_ch_gen per channel.
module cal_multi_gen
  import cal_pkg::*;
#(
  parameter int CH_NUM  = 4,
  parameter int PARA_W  = 6,
  parameter int BURST_W = 8,
  parameter int CH_W    = ch_w_calc(CH_NUM)
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               cal_load,
  input  logic [CH_W-1:0]    cal_ch,
  input  logic [PARA_W-1:0]  cal_para,
  input  logic               cal_mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               cal_start,
  input  logic               cal_stop,
  output logic [CH_NUM-1:0]  cal,
  output logic               busy,
  output logic               done
);

  cal_state_e         state;
  logic [PARA_W-1:0]  shadow [CH_NUM];
  logic               mode_q;
  logic [BURST_W-1:0] burst_q;
  logic [CH_NUM-1:0]  fin_vec;
  logic               all_fin;
  logic               accept;
  logic               launch;
  logic               ch_run;
  logic               stop_req;

  // Start acceptance and per-channel run/stop qualifiers; stop beats a
  // simultaneous start, and a stop strobe in RUN already ends the current period.
  always_comb begin
    all_fin  = &fin_vec;
    accept   = (state == IDLE) && cal_start && !cal_stop;
    launch   = accept && (cal_mode || (burst_len != '0));
    ch_run   = (state == RUN) || (state == STOP);
    stop_req = (state == STOP) || ((state == RUN) && cal_stop);
  end

  // Shadow half-period registers; out-of-range channel selects match nothing.
  // NOTE: this small register array is reset explicitly because its reset value is observable.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      for (int i = 0; i < CH_NUM; i++) shadow[i] <= {PARA_W{RST_CODE_BIT}};
    end else if (cal_load) begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (cal_ch == CH_W'(i)) shadow[i] <= cal_para;
      end
    end
  end

  // Run-control FSM with registered busy and single-cycle done.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      mode_q  <= 1'b0;
      burst_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mode_q  <= cal_mode;
            burst_q <= burst_len;
            if (launch) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (all_fin) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cal_stop) begin
            state <= STOP;
          end
        end
        STOP: begin
          if (all_fin) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    cal_ch_gen #(
      .PARA_W  (PARA_W),
      .BURST_W (BURST_W)
    ) u_ch (
      .clk_sys   (clk_sys),
      .rst       (rst),
      .start     (accept),
      .launch    (launch),
      .run       (ch_run),
      .stop_req  (stop_req),
      .mode      (mode_q),
      .burst_len (burst_q),
      .para      (shadow[c]),
      .cal       (cal[c]),
      .finished  (fin_vec[c])
    );
  end

endmodule

// File: tb/tb_cal_multi_gen.sv
// Scoreboard bench for cal_multi_gen: each scenario queues the per-cycle
// {cal,busy,done} it expects from a waveform model, then pops and compares.
module tb_cal_multi_gen;

  localparam int CH  = 3;
  localparam int PW  = 6;
  localparam int BW  = 8;
  localparam int CHW = 2;
  localparam int SW  = CH + 2;

  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic          cal_load = 1'b0;
  logic [CHW-1:0] cal_ch = '0;
  logic [PW-1:0] cal_para = '0;
  logic          cal_mode = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic          cal_start = 1'b0;
  logic          cal_stop = 1'b0;
  logic [CH-1:0] cal;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;
  logic [SW-1:0] exp_q [$];
  int h  [CH];
  int np [CH];

  always #5 clk_sys = ~clk_sys;

  cal_multi_gen #(
    .CH_NUM  (CH),
    .PARA_W  (PW),
    .BURST_W (BW),
    .CH_W    (CHW)
  ) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .cal_load  (cal_load),
    .cal_ch    (cal_ch),
    .cal_para  (cal_para),
    .cal_mode  (cal_mode),
    .burst_len (burst_len),
    .cal_start (cal_start),
    .cal_stop  (cal_stop),
    .cal       (cal),
    .busy      (busy),
    .done      (done)
  );

  task automatic step();
    @(posedge clk_sys);
    #1;
    cal_load  = 1'b0;
    cal_start = 1'b0;
    cal_stop  = 1'b0;
  endtask

  task automatic advance(output logic [SW-1:0] obs, output logic [SW-1:0] expv);
    step();
    obs = {cal, busy, done};
    if (exp_q.size() > 0) expv = exp_q.pop_front();
    else expv = 'x;
  endtask

  task automatic load(input int ch, input int para);
    cal_load = 1'b1;
    cal_ch   = CHW'(ch);
    cal_para = PW'(para);
    step();
    if (ch < CH) h[ch] = para + 1;
  endtask

  task automatic push_idle(input int n, input logic d);
    for (int i = 0; i < n; i++) exp_q.push_back({{CH{1'b0}}, 1'b0, d});
  endtask

  // Queue a run: each channel high h cycles, low h cycles, for np periods,
  // then done for one cycle and an idle cycle (unless cut short by limit).
  task automatic push_wave(input int limit);
    int total;
    int n;
    total = 0;
    for (int c = 0; c < CH; c++) if (2 * h[c] * np[c] > total) total = 2 * h[c] * np[c];
    n = (limit >= 0 && limit < total) ? limit : total;
    for (int t = 0; t < n; t++) begin
      logic [CH-1:0] v;
      for (int c = 0; c < CH; c++) v[c] = (t < 2 * h[c] * np[c]) && ((t % (2 * h[c])) < h[c]);
      exp_q.push_back({v, 2'b10});
    end
    if (n == total) begin
      push_idle(1, 1'b1);
      push_idle(1, 1'b0);
    end
  endtask

  task automatic test_reset();
    logic [SW-1:0] obs, expv;
    rst = 1'b1;
    push_idle(3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      advance(obs, expv);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL reset cycle %0d: got {cal,busy,done}=%b want %b", i, obs, expv);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_default_burst();
    logic [SW-1:0] obs, expv;
    int n;
    for (int c = 0; c < CH; c++) begin h[c] = 64; np[c] = 1; end
    cal_mode = 1'b0; burst_len = 8'd1;
    push_wave(-1);
    n = exp_q.size();
    cal_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      advance(obs, expv);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL default_burst cycle %0d: got {cal,busy,done}=%b want %b", i, obs, expv);
      end
    end
  endtask

  task automatic test_two_channel_burst();
    logic [SW-1:0] obs, expv;
    int n;
    load(0, 2); load(1, 0); load(2, 1);
    for (int c = 0; c < CH; c++) np[c] = 2;
    cal_mode = 1'b0; burst_len = 8'd2;
    push_wave(-1);
    n = exp_q.size();
    cal_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      advance(obs, expv);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL two_channel_burst cycle %0d: got {cal,busy,done}=%b want %b", i, obs, expv);
      end
    end
  endtask

  // Stop strobe during cycle 17 (2nd high cycle of ch0 period 3 with H=4):
  // every channel ends the period that contains cycle 17.
  task automatic test_continuous_stop();
    logic [SW-1:0] obs, expv;
    int n;
    load(0, 3);
    for (int c = 0; c < CH; c++) np[c] = 17 / (2 * h[c]) + 1;
    cal_mode = 1'b1; burst_len = 8'd0;
    push_wave(-1);
    n = exp_q.size();
    cal_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == 18) cal_stop = 1'b1;
      advance(obs, expv);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL continuous_stop cycle %0d: got {cal,busy,done}=%b want %b", i, obs, expv);
      end
    end
    cal_mode = 1'b0;
  endtask

  task automatic test_load_during_run();
    logic [SW-1:0] obs, expv;
    int n;
    for (int c = 0; c < CH; c++) np[c] = 1;
    cal_mode = 1'b0; burst_len = 8'd1;
    push_wave(-1);
    n = exp_q.size();
    cal_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == 2) begin cal_load = 1'b1; cal_ch = 2'd0; cal_para = 6'd5; end
      if (i == 4) begin cal_load = 1'b1; cal_ch = 2'd3; cal_para = 6'd0; end
      advance(obs, expv);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL load_during_run cycle %0d: got {cal,busy,done}=%b want %b", i, obs, expv);
      end
    end
    h[0] = 6;
    push_wave(-1);
    n = exp_q.size();
    cal_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      advance(obs, expv);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL load_next_run cycle %0d: got {cal,busy,done}=%b want %b", i, obs, expv);
      end
    end
  endtask

  task automatic test_edge_cases();
    logic [SW-1:0] obs, expv;
    int n;
    // Burst of zero periods: immediate done, no busy, no cal activity.
    cal_mode = 1'b0; burst_len = 8'd0;
    push_idle(1, 1'b1);
    push_idle(1, 1'b0);
    n = exp_q.size();
    cal_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      advance(obs, expv);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL burst_zero cycle %0d: got {cal,busy,done}=%b want %b", i, obs, expv);
      end
    end
    // Start and stop together: nothing happens.
    burst_len = 8'd1;
    push_idle(3, 1'b0);
    n = exp_q.size();
    cal_start = 1'b1; cal_stop = 1'b1;
    for (int i = 0; i < n; i++) begin
      advance(obs, expv);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL start_with_stop cycle %0d: got {cal,busy,done}=%b want %b", i, obs, expv);
      end
    end
    // Start during RUN is ignored, even with different mode/length presented.
    for (int c = 0; c < CH; c++) np[c] = 1;
    push_wave(-1);
    n = exp_q.size();
    cal_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == 3) begin cal_start = 1'b1; cal_mode = 1'b1; burst_len = 8'd3; end
      advance(obs, expv);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL start_in_run cycle %0d: got {cal,busy,done}=%b want %b", i, obs, expv);
      end
    end
    // Stop on the edge the burst completes: plain completion, one done.
    cal_mode = 1'b0; burst_len = 8'd1;
    push_wave(-1);
    n = exp_q.size();
    cal_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == 12) cal_stop = 1'b1;
      advance(obs, expv);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL stop_at_completion cycle %0d: got {cal,busy,done}=%b want %b", i, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [SW-1:0] obs, expv;
    int n;
    for (int c = 0; c < CH; c++) np[c] = 100;
    cal_mode = 1'b1;
    push_wave(5);
    push_idle(4, 1'b0);
    n = exp_q.size();
    cal_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == 5) rst = 1'b1;
      if (i == 7) rst = 1'b0;
      advance(obs, expv);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL reset_mid_run cycle %0d: got {cal,busy,done}=%b want %b", i, obs, expv);
      end
    end
    for (int c = 0; c < CH; c++) begin h[c] = 64; np[c] = 1; end
    cal_mode = 1'b0; burst_len = 8'd1;
    push_wave(-1);
    n = exp_q.size();
    cal_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      advance(obs, expv);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL run_after_reset cycle %0d: got {cal,busy,done}=%b want %b", i, obs, expv);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int c = 0; c < CH; c++) begin h[c] = 64; np[c] = 1; end
    test_reset();
    test_default_burst();
    test_two_channel_burst();
    test_continuous_stop();
    test_load_during_run();
    test_edge_cases();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
